// File: rtl/mem_port_ctrl_pkg.sv
// Shared encodings for the memory port controller and the control unit that drives it.
//   mem_state_e  : 2-bit FSM state encoding (idle, access, wait, complete)
//   mem_op_e     : latched operation (read / write)
//   WaitCntWidth : width of the wait-state counter (supports 0..15 wait states)
package mem_port_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'b00,
    StAccess   = 2'b01,
    StWait     = 2'b10,
    StComplete = 2'b11
  } mem_state_e;

  typedef enum logic {
    OpRd = 1'b0,
    OpWr = 1'b1
  } mem_op_e;

  localparam int unsigned WaitCntWidth = 4;

endpackage

// File: rtl/mem_wait_counter.sv
// Wait-state counter for the memory port controller.
// Counts 0..WaitStates-1 while enabled and flags the last wait cycle.
// Ports:
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset
//   clr_i   : synchronous clear (has priority over en_i)
//   en_i    : count enable
//   tc_o    : terminal count, high while the count sits on the last wait cycle
module mem_wait_counter
  import mem_port_ctrl_pkg::*;
#(
  parameter int unsigned WaitStates = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  // With zero wait states the controller never enables the counter, so the
  // terminal value is irrelevant; pin it at 0 to keep the arithmetic defined.
  localparam logic [WaitCntWidth-1:0] LastCount =
    WaitCntWidth'((WaitStates == 0) ? 0 : WaitStates - 1);

  logic [WaitCntWidth-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == LastCount);

endmodule

// File: rtl/mem_port_ctrl.sv
// Memory port controller: latches the AR address and bus write data on a control-unit request,
// runs one read or write cycle on the synchronous data memory with WAIT_STATES wait cycles, then
// returns read data and a one-cycle done pulse.
// Ports:
//   clk        : clock, rising edge
//   reset      : asynchronous active-low reset
//   addr_in    : address from AR
//   wdata_in   : write data from the bus
//   rd_req     : read request, sampled only when idle
//   wr_req     : write request, sampled only when idle (wins over rd_req)
//   busy       : high whenever an access is in progress
//   done       : one-cycle pulse when the access completes
//   rdata_out  : last read data, held until the next completed read
//   mem_addr   : latched memory address
//   mem_wdata  : latched memory write data
//   mem_re     : read strobe, access cycle only
//   mem_we     : write strobe, access cycle only
//   mem_rdata  : memory read data, captured at the edge leaving the last wait cycle
module mem_port_ctrl
  import mem_port_ctrl_pkg::*;
#(
  parameter int unsigned reg_width   = 12,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [reg_width-1:0] addr_in,
  input  logic [reg_width-1:0] wdata_in,
  input  logic                 rd_req,
  input  logic                 wr_req,
  output logic                 busy,
  output logic                 done,
  output logic [reg_width-1:0] rdata_out,
  output logic [reg_width-1:0] mem_addr,
  output logic [reg_width-1:0] mem_wdata,
  output logic                 mem_re,
  output logic                 mem_we,
  input  logic [reg_width-1:0] mem_rdata
);

  localparam bit NoWait = (WAIT_STATES == 0);

  mem_state_e           state_d, state_q;
  mem_op_e              op_d, op_q;
  logic [reg_width-1:0] addr_d, addr_q;
  logic [reg_width-1:0] wdata_d, wdata_q;
  logic [reg_width-1:0] rdata_d, rdata_q;
  logic                 cnt_clr, cnt_en, cnt_tc;

  mem_wait_counter #(
    .WaitStates(WAIT_STATES)
  ) u_wait_counter (
    .clk_i (clk),
    .rst_ni(reset),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .tc_o  (cnt_tc)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_clr = 1'b1;
        if (wr_req || rd_req) begin
          addr_d  = addr_in;
          wdata_d = wdata_in;
          // Write takes precedence; a simultaneous read is dropped.
          op_d    = wr_req ? OpWr : OpRd;
          state_d = StAccess;
        end
      end
      StAccess: begin
        if (NoWait) begin
          // No wait cycles: read data is already valid at the edge leaving access.
          state_d = StComplete;
          if (op_q == OpRd) begin
            rdata_d = mem_rdata;
          end
        end else begin
          state_d = StWait;
        end
      end
      StWait: begin
        cnt_en = 1'b1;
        if (cnt_tc) begin
          state_d = StComplete;
          if (op_q == OpRd) begin
            rdata_d = mem_rdata;
          end
        end
      end
      StComplete: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      op_q    <= OpRd;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs decode only flopped state, so requests never reach them combinationally
  // and reset clears the strobes asynchronously.
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StComplete);
  assign mem_re    = (state_q == StAccess) && (op_q == OpRd);
  assign mem_we    = (state_q == StAccess) && (op_q == OpWr);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata_out = rdata_q;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Bench for mem_port_ctrl: one instance with 2 wait states (port 0) and one with none (port 1),
// sharing a memory model. A stimulus process pushes expected transactions; a monitor checks.
module tb_mem_port_ctrl;

  localparam int W = 12;

  typedef struct {
    int           port;
    bit           wr;
    logic [W-1:0] addr;
    logic [W-1:0] wdata;
    logic [W-1:0] exp_rdata;
    int           e0;
  } txn_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] addr_in, wdata_in;
  logic         rd_req [2];
  logic         wr_req [2];
  logic         busy [2];
  logic         done [2];
  logic         mem_re [2];
  logic         mem_we [2];
  logic [W-1:0] rdata_out [2];
  logic [W-1:0] mem_addr [2];
  logic [W-1:0] mem_wdata [2];
  logic [W-1:0] mem_rdata [2];

  int           cyc = 0;
  int           n_cmp = 0;
  int           n_bad = 0;
  bit           stim_done = 1'b0;
  bit           prev_rst = 1'b0;
  txn_t         sb[$];
  logic [W-1:0] ref_mem [4096];
  logic [W-1:0] last_rd [2];
  int           next_ok [2];

  mem_port_ctrl #(.reg_width(W), .WAIT_STATES(2)) u_dut_ws2 (
    .clk(clk), .reset(reset), .addr_in(addr_in), .wdata_in(wdata_in),
    .rd_req(rd_req[0]), .wr_req(wr_req[0]), .busy(busy[0]), .done(done[0]),
    .rdata_out(rdata_out[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_re(mem_re[0]), .mem_we(mem_we[0]), .mem_rdata(mem_rdata[0])
  );

  mem_port_ctrl #(.reg_width(W), .WAIT_STATES(0)) u_dut_ws0 (
    .clk(clk), .reset(reset), .addr_in(addr_in), .wdata_in(wdata_in),
    .rd_req(rd_req[1]), .wr_req(wr_req[1]), .busy(busy[1]), .done(done[1]),
    .rdata_out(rdata_out[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_re(mem_re[1]), .mem_we(mem_we[1]), .mem_rdata(mem_rdata[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ws_of(input int p);
    return (p == 0) ? 2 : 0;
  endfunction

  function automatic logic [W-1:0] init_val(input int i);
    if (i == 'h0A5) return 12'h3C7;
    return 12'((i * 37) ^ 'h159);
  endfunction

  // Memory model: data is only valid in the cycle that ends with the capture edge
  // (WAIT_STATES cycles after the strobe cycle); otherwise it presents inverted data.
  initial begin : mem_model
    logic [W-1:0] mem [4096];
    int           k [2];
    for (int i = 0; i < 4096; i++) mem[i] = init_val(i);
    k[0] = -1;
    k[1] = -1;
    mem_rdata[0] = '0;
    mem_rdata[1] = '0;
    forever begin
      @(negedge clk or negedge reset);
      for (int p = 0; p < 2; p++) begin
        if (!reset) k[p] = -1;
        else if (mem_re[p]) k[p] = 0;
        else if (k[p] >= 0 && k[p] < 100) k[p] = k[p] + 1;
        if (reset && mem_we[p]) mem[mem_addr[p]] = mem_wdata[p];
        mem_rdata[p] = (k[p] == ws_of(p)) ? mem[mem_addr[p]] : ~mem[mem_addr[p]];
      end
    end
  end

  task automatic chk(input string what, input int p, input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s port%0d cycle %0d: got %h, expected %h", what, p, cyc, got, exp);
    end
  endtask

  task automatic check_port(input int p);
    txn_t t;
    bit   have, act, e_re, e_we, e_done;
    have = (sb.size() > 0) && (sb[0].port == p);
    if (have) t = sb[0];
    act    = have && (cyc >= t.e0);
    e_re   = have && (cyc == t.e0) && !t.wr;
    e_we   = have && (cyc == t.e0) && t.wr;
    e_done = have && (cyc == t.e0 + 1 + ws_of(p));
    chk("busy", p, {11'b0, busy[p]}, {11'b0, act});
    chk("mem_re", p, {11'b0, mem_re[p]}, {11'b0, e_re});
    chk("mem_we", p, {11'b0, mem_we[p]}, {11'b0, e_we});
    chk("done", p, {11'b0, done[p]}, {11'b0, e_done});
    if (act) begin
      chk("mem_addr", p, mem_addr[p], t.addr);
      chk("mem_wdata", p, mem_wdata[p], t.wdata);
    end
    if (e_done) begin
      chk("rdata_out", p, rdata_out[p], t.exp_rdata);
      void'(sb.pop_front());
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk or negedge reset);
      if (!reset && prev_rst) begin
        #1;
        for (int p = 0; p < 2; p++) begin
          chk("rst_busy", p, {11'b0, busy[p]}, '0);
          chk("rst_done", p, {11'b0, done[p]}, '0);
          chk("rst_mem_re", p, {11'b0, mem_re[p]}, '0);
          chk("rst_mem_we", p, {11'b0, mem_we[p]}, '0);
          chk("rst_rdata_out", p, rdata_out[p], '0);
          chk("rst_mem_addr", p, mem_addr[p], '0);
          chk("rst_mem_wdata", p, mem_wdata[p], '0);
        end
        sb.delete();
      end else begin
        for (int p = 0; p < 2; p++) check_port(p);
        if (stim_done) begin
          chk("scoreboard_drained", 0, 12'(sb.size()), '0);
          $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
          $finish;
        end
      end
      prev_rst = reset;
    end
  end

  // One cycle of stimulus on port p; the reference decides acceptance from the
  // idle-to-idle spacing of WAIT_STATES+3 cycles.
  task automatic drive(input int p, input bit rd, input bit wr, input logic [W-1:0] a,
                       input logic [W-1:0] d);
    txn_t t;
    int   e;
    @(negedge clk);
    addr_in  = a;
    wdata_in = d;
    for (int q = 0; q < 2; q++) begin
      rd_req[q] = (q == p) && rd;
      wr_req[q] = (q == p) && wr;
    end
    e = cyc + 1;
    if ((rd || wr) && e >= next_ok[p]) begin
      t.port  = p;
      t.wr    = wr;
      t.addr  = a;
      t.wdata = d;
      t.e0    = e;
      if (wr) begin
        t.exp_rdata = last_rd[p];
        ref_mem[a]  = d;
      end else begin
        t.exp_rdata = ref_mem[a];
        last_rd[p]  = ref_mem[a];
      end
      next_ok[p] = e + ws_of(p) + 3;
      sb.push_back(t);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 1'b0, 1'b0, 12'h000, 12'h000);
  endtask

  task automatic reset_models();
    for (int p = 0; p < 2; p++) begin
      next_ok[p] = 0;
      last_rd[p] = '0;
    end
  endtask

  initial begin : stim
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(i);
    addr_in  = '0;
    wdata_in = '0;
    for (int p = 0; p < 2; p++) begin
      rd_req[p] = 1'b0;
      wr_req[p] = 1'b0;
    end
    reset_models();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Directed accesses on the two-wait-state port.
    drive(0, 1'b1, 1'b0, 12'h0A5, 12'h000); idle(6);
    drive(0, 1'b0, 1'b1, 12'hE08, 12'hFF8); idle(6);
    drive(0, 1'b1, 1'b1, 12'h0B0, 12'h0AA); idle(6);
    drive(0, 1'b1, 1'b0, 12'h055, 12'h000);
    repeat (3) drive(0, 1'b1, 1'b0, 12'h123, 12'h000);
    idle(5);

    // Abort a read during its first wait cycle.
    drive(0, 1'b1, 1'b0, 12'h0A5, 12'h000);
    idle(2);
    #2;
    reset = 1'b0;
    reset_models();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    drive(0, 1'b1, 1'b0, 12'h0A5, 12'h000); idle(6);

    repeat (200) drive(0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                       12'($urandom), 12'($urandom));
    idle(6);

    // Zero-wait-state port: single read, then a request held high.
    drive(1, 1'b1, 1'b0, 12'h001, 12'h000); idle(4);
    repeat (12) drive(1, 1'b1, 1'b0, 12'h001, 12'h000);
    idle(4);
    repeat (150) drive(1, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                       12'($urandom), 12'($urandom));
    idle(4);
    stim_done = 1'b1;
  end

endmodule
